// File: rtl/gray_disp_scan.sv
// gray_disp_scan: drives an external Gray 7-segment decoder and time-multiplexes
// its two digit outputs onto one shared segment bus. A new value is accepted over
// a valid/ready handshake into a one-entry buffer. It is committed only at the
// start of a frame, so a frame never shows two different values.
//
// Frame: BLANK_R (1) -> SHOW_R (TICK_CYC) -> BLANK_L (1) -> SHOW_L (TICK_CYC).
// The blank cycles keep both digit enables low between digits.
//
// Optional feature: define GRAY_DISP_BLINK_EN to add the 'blink' input. While
// blink is high, the digits are dark for 4 frames out of every 8.
//
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   in_valid   producer has a value
//   in_data    value to display (0..15)
//   in_ready   one-entry buffer free
//   auto_en    auto-step mode: increment value every AUTO_FRAMES frames
//   blink      (GRAY_DISP_BLINK_EN only) blink the display
//   dec_num    value driven to the Gray decoder
//   dec_iz     decoder left-digit segments
//   dec_der    decoder right-digit segments
//   seg        shared segment bus, active-high, abcdefg
//   dig_en     digit enables, bit0 = right, bit1 = left
//   frame_stb  one-cycle pulse at the start of each frame

`timescale 1ns/1ps

module gray_disp_scan #(
    parameter int unsigned TICK_CYC    = 1000,
    parameter int unsigned AUTO_FRAMES = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       auto_en,
`ifdef GRAY_DISP_BLINK_EN
    input  logic       blink,
`endif
    output logic [3:0] dec_num,
    input  logic [6:0] dec_iz,
    input  logic [6:0] dec_der,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       frame_stb
);

    localparam int unsigned CntW = $clog2(TICK_CYC);
    localparam int unsigned FcW  = $clog2(AUTO_FRAMES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_CYC - 1);
    localparam logic [FcW-1:0]  FcLast  = FcW'(AUTO_FRAMES - 1);

    typedef enum logic [1:0] {
        StBlankR,
        StShowR,
        StBlankL,
        StShowL
    } state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      cur_val_q, cur_val_d;
    logic [3:0]      pend_val_q, pend_val_d;
    logic            pend_full_q, pend_full_d;
    logic [FcW-1:0]  fc_q, fc_d;
    logic [1:0]      dig_en_fsm;
    logic            xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StBlankR;
            cnt_q       <= '0;
            cur_val_q   <= '0;
            pend_val_q  <= '0;
            pend_full_q <= 1'b0;
            fc_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_val_q   <= cur_val_d;
            pend_val_q  <= pend_val_d;
            pend_full_q <= pend_full_d;
            fc_q        <= fc_d;
        end
    end

    // Sequencing and tick counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StBlankR: state_d = StShowR;
            StShowR: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StBlankL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBlankL: state_d = StShowL;
            StShowL: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StBlankR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StBlankR;
        endcase
    end

    assign in_ready = ~pend_full_q & ~rst;
    assign xfer     = in_valid & in_ready;

    // Handshake capture and frame-boundary commit. A transfer needs an empty
    // buffer and a commit load needs a full one, so the two never collide.
    always_comb begin
        cur_val_d   = cur_val_q;
        pend_val_d  = pend_val_q;
        pend_full_d = pend_full_q;
        fc_d        = fc_q;
        if (xfer) begin
            pend_val_d  = in_data;
            pend_full_d = 1'b1;
        end
        if (state_q == StBlankR) begin
            if (pend_full_q) begin
                cur_val_d   = pend_val_q;
                pend_full_d = 1'b0;
                fc_d        = '0;
            end else if (auto_en) begin
                if (fc_q == FcLast) begin
                    cur_val_d = cur_val_q + 4'd1;
                    fc_d      = '0;
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end else begin
                fc_d = '0;
            end
        end
    end

    // Moore outputs
    always_comb begin
        seg        = 7'b0000000;
        dig_en_fsm = 2'b00;
        unique case (state_q)
            StShowR: begin
                seg        = dec_der;
                dig_en_fsm = 2'b01;
            end
            StShowL: begin
                seg        = dec_iz;
                dig_en_fsm = 2'b10;
            end
            default: begin
                seg        = 7'b0000000;
                dig_en_fsm = 2'b00;
            end
        endcase
    end

    // Gated so the strobe stays low while reset is held
    assign frame_stb = (state_q == StBlankR) & ~rst;
    assign dec_num   = cur_val_q;

`ifdef GRAY_DISP_BLINK_EN
    logic [2:0] blink_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_q <= '0;
        end else if (state_q == StBlankR) begin
            blink_q <= blink_q + 3'd1;
        end
    end

    // Only the enables are masked; seg and timing run on unchanged
    assign dig_en = (blink & blink_q[2]) ? 2'b00 : dig_en_fsm;
`else
    assign dig_en = dig_en_fsm;
`endif

endmodule

// File: tb/tb_gray_disp_scan.sv
`timescale 1ns/1ps

module tb_gray_disp_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       auto_en;
    logic [3:0] dec_num;
    logic [6:0] dec_iz;
    logic [6:0] dec_der;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       frame_stb;
`ifdef GRAY_DISP_BLINK_EN
    logic       blink;
    logic [2:0] bcnt = 3'd0;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_stb = 0;
    bit stb_seen = 1'b0;

    always #5 clk = ~clk;

    gray_disp_scan #(
        .TICK_CYC   (4),
        .AUTO_FRAMES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .auto_en  (auto_en),
`ifdef GRAY_DISP_BLINK_EN
        .blink    (blink),
`endif
        .dec_num  (dec_num),
        .dec_iz   (dec_iz),
        .dec_der  (dec_der),
        .seg      (seg),
        .dig_en   (dig_en),
        .frame_stb(frame_stb)
    );

    // Model of the attached Gray decoder: binary -> Gray, shown as two decimal digits
    function automatic logic [6:0] seven(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] der_of(input logic [3:0] n);
        logic [3:0] g;
        g = n ^ (n >> 1);
        return seven((g >= 4'd10) ? g - 4'd10 : g);
    endfunction

    function automatic logic [6:0] iz_of(input logic [3:0] n);
        logic [3:0] g;
        g = n ^ (n >> 1);
        return (g >= 4'd10) ? 7'b0110000 : 7'b0000000;
    endfunction

    assign dec_der = der_of(dec_num);
    assign dec_iz  = iz_of(dec_num);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1ns after the edge. Also watches dig_en and frame_stb spacing.
    task automatic step();
`ifdef GRAY_DISP_BLINK_EN
        logic [2:0] bn;
        if (rst) bn = 3'd0;
        else if (frame_stb === 1'b1) bn = bcnt + 3'd1;
        else bn = bcnt;
`endif
        @(posedge clk);
        #1;
        cyc++;
`ifdef GRAY_DISP_BLINK_EN
        bcnt = bn;
`endif
        chk("dig_en_not_11", {31'd0, dig_en === 2'b11}, 32'd0);
        if (rst) begin
            stb_seen = 1'b0;
        end else if (frame_stb === 1'b1) begin
            if (stb_seen) chk("stb_period", cyc - last_stb, 32'd10);
            last_stb = cyc;
            stb_seen = 1'b1;
        end
    endtask

    // Checks one whole frame starting at a BLANK_R sample; ends at the next BLANK_R
    task automatic frame(input logic [3:0] n, input logic [6:0] der, input logic [6:0] iz);
        chk("br_stb", frame_stb, 1);
        chk("br_dig", dig_en, 2'b00);
        chk("br_seg", seg, 7'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sr_dig", dig_en, 2'b01);
            chk("sr_seg", seg, der);
            chk("sr_num", dec_num, n);
        end
        step();
        chk("bl_dig", dig_en, 2'b00);
        chk("bl_seg", seg, 7'b0);
        chk("bl_stb", frame_stb, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("sl_dig", dig_en, 2'b10);
            chk("sl_seg", seg, iz);
        end
        step();
    endtask

    // From BLANK_R: checks dec_num in SHOW_R, ends at the next BLANK_R
    task automatic shown(input logic [3:0] n);
        step();
        chk("auto_num", dec_num, n);
        repeat (9) step();
    endtask

    // From BLANK_R: hands over v in SHOW_R, ends at the next BLANK_R with it pending
    task automatic send(input logic [3:0] v);
        step();
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'd0;
        auto_en  = 1'b0;
`ifdef GRAY_DISP_BLINK_EN
        blink    = 1'b0;
`endif

        // 1. Reset and first frame showing 0
        repeat (3) step();
        chk("rst_seg", seg, 7'b0);
        chk("rst_dig", dig_en, 2'b00);
        chk("rst_rdy", in_ready, 0);
        chk("rst_stb", frame_stb, 0);
        chk("rst_num", dec_num, 4'd0);
        rst = 1'b0;
        #1;
        chk("rel_rdy", in_ready, 1);
        frame(4'd0, 7'b1111110, 7'b0000000);

        // 2. Value 10 sent during SHOW_R, committed at the next frame
        step();
        in_valid = 1'b1;
        in_data  = 4'd10;
        chk("t2_rdy_pre", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t2_rdy_drop", in_ready, 0);
        repeat (8) step();
        chk("t2_rdy_blank", in_ready, 0);
        chk("t2_num_blank", dec_num, 4'd0);
        frame(4'd10, 7'b1011011, 7'b0110000);
        chk("t2_rdy_back", in_ready, 1);

        // 3. 5 then 9 back-to-back: 9 stalls until 5 is committed
        step();
        in_valid = 1'b1;
        in_data  = 4'd5;
        chk("t3_rdy5", in_ready, 1);
        step();
        in_data = 4'd9;
        for (int i = 0; i < 8; i++) begin
            chk("t3_stall", in_ready, 0);
            step();
        end
        chk("t3_rdy_blank", in_ready, 0);
        chk("t3_num_old", dec_num, 4'd10);
        step();
        chk("t3_num5", dec_num, 4'd5);
        chk("t3_seg5", seg, 7'b1110000);
        chk("t3_rdy9", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("t3_rdy_full9", in_ready, 0);
        chk("t3_num5_hold", dec_num, 4'd5);
        repeat (8) step();
        frame(4'd9, 7'b1111001, 7'b0110000);
        chk("t3_rdy_end", in_ready, 1);

        // 4. Auto-step from 15 with wrap, then a load of 3 at a step frame
        send(4'd15);
        auto_en = 1'b1;
        shown(4'd15);
        shown(4'd15);
        shown(4'd0);
        shown(4'd0);
        shown(4'd1);
        step();
        chk("t4_num1", dec_num, 4'd1);
        in_valid = 1'b1;
        in_data  = 4'd3;
        step();
        in_valid = 1'b0;
        chk("t4_rdy_full", in_ready, 0);
        repeat (8) step();
        shown(4'd3);
        shown(4'd3);
        shown(4'd4);
        auto_en = 1'b0;

        // 5. Reset in the 2nd SHOW_L cycle with a value pending
        step();
        in_valid = 1'b1;
        in_data  = 4'd6;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("t5_dig_l", dig_en, 2'b10);
        chk("t5_pend", in_ready, 0);
        rst = 1'b1;
        step();
        chk("t5_dig_off", dig_en, 2'b00);
        chk("t5_num", dec_num, 4'd0);
        chk("t5_seg", seg, 7'b0);
        chk("t5_rdy_rst", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("t5_rdy_rel", in_ready, 1);
        frame(4'd0, 7'b1111110, 7'b0000000);
        chk("t5_rdy_end", in_ready, 1);

`ifdef GRAY_DISP_BLINK_EN
        // 6. Blink: digits dark while the frame counter's bit 2 is set
        blink = 1'b1;
        for (int f = 0; f < 9; f++) begin
            step();
            chk("t6_dig", dig_en, bcnt[2] ? 2'b00 : 2'b01);
            chk("t6_seg", seg, 7'b1111110);
            repeat (9) step();
        end
        blink = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
